// File: rtl/vga_timing_pkg.sv
// Default VGA timing constants and small helpers shared by the scaled-window raster engine.
package vga_timing_pkg;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;
    localparam int DEF_COLOR_W  = 4;

    localparam int DEF_H_TOTAL = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOTAL = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
    localparam int DEF_RGB_W   = 3 * DEF_COLOR_W;

    typedef struct packed {
        logic [DEF_COLOR_W-1:0] r;
        logic [DEF_COLOR_W-1:0] g;
        logic [DEF_COLOR_W-1:0] b;
    } rgb_t;

    function automatic int line_total(int active, int fp, int sync, int bp);
        return active + fp + sync + bp;
    endfunction

    // Bits needed to hold 0..v-1, never less than one.
    function automatic int clog2_min1(int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

    function automatic int rgb_width(int color_w);
        return 3 * color_w;
    endfunction

endpackage

// File: rtl/vga_delay_line.sv
// WIDTH x DEPTH shift register with asynchronous active-low clear.
module vga_delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = d;
        for (int i = 1; i < DEPTH; i++) begin
            stage_d[i] = stage_q[i-1];
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q[DEPTH-1];

endmodule

// File: rtl/vga_scaled_window.sv
// VGA raster engine: H/V timing, incremental zoomed image fetch from a synchronous RAM,
// and registered RGB/sync outputs aligned to the RAM read latency.
module vga_scaled_window
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE  = DEF_H_ACTIVE,
    parameter int   H_FP      = DEF_H_FP,
    parameter int   H_SYNC    = DEF_H_SYNC,
    parameter int   H_BP      = DEF_H_BP,
    parameter int   V_ACTIVE  = DEF_V_ACTIVE,
    parameter int   V_FP      = DEF_V_FP,
    parameter int   V_SYNC    = DEF_V_SYNC,
    parameter int   V_BP      = DEF_V_BP,
    parameter logic SYNC_POL  = 1'b0,
    parameter int   CNT_W     = 11,
    parameter int   IMG_W     = 120,
    parameter int   IMG_H     = 120,
    parameter int   X_OFF     = 0,
    parameter int   Y_OFF     = 0,
    parameter int   MAX_SCALE = 4,
    parameter int   ZOOM_W    = 3,
    parameter int   ADDR_W    = 14,
    parameter int   COLOR_W   = DEF_COLOR_W,
    parameter int   RD_LAT    = 1
) (
    input  logic                   clock,
    input  logic                   reset_n,
    input  logic [ZOOM_W-1:0]      zoom,
    input  logic [3*COLOR_W-1:0]   border_rgb,
    output logic                   rd_en,
    output logic [ADDR_W-1:0]      rd_addr,
    input  logic [3*COLOR_W-1:0]   rd_data,
    output logic                   hsync,
    output logic                   vsync,
    output logic                   de,
    output logic                   frame_start,
    output logic [COLOR_W-1:0]     red,
    output logic [COLOR_W-1:0]     gre,
    output logic [COLOR_W-1:0]     blu
);

    localparam int H_TOTAL = line_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = line_total(V_ACTIVE, V_FP, V_SYNC, V_BP);
    localparam int HA0     = H_SYNC + H_BP;
    localparam int VA0     = V_SYNC + V_BP;
    localparam int SC_W    = clog2_min1(MAX_SCALE + 1);
    localparam int COL_W   = clog2_min1(IMG_W);
    localparam int RGB_W   = rgb_width(COLOR_W);

    localparam logic [CNT_W-1:0]  H_LAST   = CNT_W'(H_TOTAL - 1);
    localparam logic [CNT_W-1:0]  V_LAST   = CNT_W'(V_TOTAL - 1);
    localparam logic [CNT_W-1:0]  HS_END   = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0]  VS_END   = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0]  HA_BEG   = CNT_W'(HA0);
    localparam logic [CNT_W-1:0]  HA_END   = CNT_W'(HA0 + H_ACTIVE);
    localparam logic [CNT_W-1:0]  VA_BEG   = CNT_W'(VA0);
    localparam logic [CNT_W-1:0]  VA_END   = CNT_W'(VA0 + V_ACTIVE);
    localparam logic [CNT_W-1:0]  WX_BEG   = CNT_W'(HA0 + X_OFF);
    localparam logic [CNT_W-1:0]  WY_BEG   = CNT_W'(VA0 + Y_OFF);
    localparam logic [COL_W-1:0]  COL_LAST = COL_W'(IMG_W - 1);
    localparam logic [ADDR_W-1:0] ROW_STEP = ADDR_W'(IMG_W);
    localparam logic [ADDR_W-1:0] LAST_ROW = ADDR_W'((IMG_H - 1) * IMG_W);
    localparam logic [ZOOM_W-1:0] ZOOM_MAX = ZOOM_W'(MAX_SCALE);
    localparam logic [SC_W-1:0]   SC_ONE   = SC_W'(1);
    localparam logic [SC_W-1:0]   SC_MAX   = SC_W'(MAX_SCALE);

    logic [CNT_W-1:0]  h_cnt_q, h_cnt_d, v_cnt_q, v_cnt_d;
    logic [SC_W-1:0]   scale_q, scale_d, sx_q, sx_d, sy_q, sy_d;
    logic [COL_W-1:0]  col_q, col_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d, rd_addr_q, rd_addr_d;
    logic              x_done_q, x_done_d, y_done_q, y_done_d, rd_en_q, rd_en_d;
    logic              hsync_q, hsync_d, vsync_q, vsync_d, de_q, de_d, fs_q, fs_d;
    logic [RGB_W-1:0]  rgb_q, rgb_d;
    logic              line_end, frame_end, active, x_win, y_win, in_win;
    logic [4:0]        flags, flags_dl;

    always_comb begin
        line_end  = (h_cnt_q == H_LAST);
        frame_end = line_end && (v_cnt_q == V_LAST);
        active    = (h_cnt_q >= HA_BEG) && (h_cnt_q < HA_END) &&
                    (v_cnt_q >= VA_BEG) && (v_cnt_q < VA_END);
        // Horizontal/vertical window runs until the image is exhausted or the active area ends.
        x_win     = (h_cnt_q >= WX_BEG) && (h_cnt_q < HA_END) && !x_done_q;
        y_win     = (v_cnt_q >= WY_BEG) && (v_cnt_q < VA_END) && !y_done_q;
        in_win    = x_win && y_win;

        h_cnt_d = line_end ? '0 : h_cnt_q + 1'b1;
        v_cnt_d = v_cnt_q;
        if (line_end) v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;

        scale_d = scale_q;
        if (frame_end) begin
            if (zoom == '0)            scale_d = SC_ONE;
            else if (zoom > ZOOM_MAX)  scale_d = SC_MAX;
            else                       scale_d = SC_W'(zoom);
        end

        sx_d     = sx_q;
        col_d    = col_q;
        x_done_d = x_done_q;
        if (line_end) begin
            sx_d     = '0;
            col_d    = '0;
            x_done_d = 1'b0;
        end else if (x_win) begin
            if (sx_q == scale_q - SC_ONE) begin
                sx_d = '0;
                if (col_q == COL_LAST) x_done_d = 1'b1;
                else                   col_d    = col_q + 1'b1;
            end else begin
                sx_d = sx_q + SC_ONE;
            end
        end

        sy_d       = sy_q;
        row_base_d = row_base_q;
        y_done_d   = y_done_q;
        if (frame_end) begin
            sy_d       = '0;
            row_base_d = '0;
            y_done_d   = 1'b0;
        end else if (line_end && y_win) begin
            if (sy_q == scale_q - SC_ONE) begin
                sy_d = '0;
                if (row_base_q == LAST_ROW) y_done_d   = 1'b1;
                else                        row_base_d = row_base_q + ROW_STEP;
            end else begin
                sy_d = sy_q + SC_ONE;
            end
        end

        rd_en_d   = in_win;
        rd_addr_d = row_base_q + ADDR_W'(col_q);

        flags = {h_cnt_q < HS_END, v_cnt_q < VS_END, active, in_win,
                 (h_cnt_q == HA_BEG) && (v_cnt_q == VA_BEG)};
    end

    // One stage short of the full latency: the output registers below supply the last one.
    vga_delay_line #(
        .WIDTH (5),
        .DEPTH (RD_LAT + 1)
    ) u_delay (
        .clock   (clock),
        .reset_n (reset_n),
        .d       (flags),
        .q       (flags_dl)
    );

    always_comb begin
        hsync_d = flags_dl[4] ? SYNC_POL : ~SYNC_POL;
        vsync_d = flags_dl[3] ? SYNC_POL : ~SYNC_POL;
        de_d    = flags_dl[2];
        fs_d    = flags_dl[0];
        if (flags_dl[1])      rgb_d = rd_data;
        else if (flags_dl[2]) rgb_d = border_rgb;
        else                  rgb_d = '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt_q    <= '0;
            v_cnt_q    <= '0;
            scale_q    <= SC_ONE;
            sx_q       <= '0;
            sy_q       <= '0;
            col_q      <= '0;
            row_base_q <= '0;
            x_done_q   <= 1'b0;
            y_done_q   <= 1'b0;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            hsync_q    <= ~SYNC_POL;
            vsync_q    <= ~SYNC_POL;
            de_q       <= 1'b0;
            fs_q       <= 1'b0;
            rgb_q      <= '0;
        end else begin
            h_cnt_q    <= h_cnt_d;
            v_cnt_q    <= v_cnt_d;
            scale_q    <= scale_d;
            sx_q       <= sx_d;
            sy_q       <= sy_d;
            col_q      <= col_d;
            row_base_q <= row_base_d;
            x_done_q   <= x_done_d;
            y_done_q   <= y_done_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            hsync_q    <= hsync_d;
            vsync_q    <= vsync_d;
            de_q       <= de_d;
            fs_q       <= fs_d;
            rgb_q      <= rgb_d;
        end
    end

    assign rd_en       = rd_en_q;
    assign rd_addr     = rd_addr_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign de          = de_q;
    assign frame_start = fs_q;
    assign red         = rgb_q[3*COLOR_W-1 -: COLOR_W];
    assign gre         = rgb_q[2*COLOR_W-1 -: COLOR_W];
    assign blu         = rgb_q[COLOR_W-1:0];

endmodule

// File: tb/tb_vga_scaled_window.sv
// Scoreboard bench: a raster/zoom reference model predicts every output cycle and RAM request.
module tb_vga_scaled_window;

    localparam int   H_ACTIVE = 40, H_FP = 4, H_SYNC = 6, H_BP = 5;
    localparam int   V_ACTIVE = 30, V_FP = 2, V_SYNC = 2, V_BP = 3;
    localparam logic SYNC_POL = 1'b0;
    localparam int   CNT_W = 8, IMG_W = 8, IMG_H = 6, X_OFF = 10, Y_OFF = 8;
    localparam int   MAX_SCALE = 4, ZOOM_W = 3, ADDR_W = 8, COLOR_W = 4, RD_LAT = 2;
    localparam int   H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int   V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int   FRAME = H_TOT * V_TOT;
    localparam int   HA0 = H_SYNC + H_BP;
    localparam int   VA0 = V_SYNC + V_BP;
    localparam int   L = RD_LAT + 2;
    localparam int   RGB_W = 3 * COLOR_W;

    logic               clock = 1'b0;
    logic               reset_n = 1'b1;
    logic [ZOOM_W-1:0]  zoom = 3'd3;
    logic [RGB_W-1:0]   border_rgb = '0;
    logic               rd_en;
    logic [ADDR_W-1:0]  rd_addr;
    logic [RGB_W-1:0]   rd_data;
    logic               hsync, vsync, de, frame_start;
    logic [COLOR_W-1:0] red, gre, blu;

    vga_scaled_window #(
        .H_ACTIVE (H_ACTIVE), .H_FP (H_FP), .H_SYNC (H_SYNC), .H_BP (H_BP),
        .V_ACTIVE (V_ACTIVE), .V_FP (V_FP), .V_SYNC (V_SYNC), .V_BP (V_BP),
        .SYNC_POL (SYNC_POL), .CNT_W (CNT_W), .IMG_W (IMG_W), .IMG_H (IMG_H),
        .X_OFF (X_OFF), .Y_OFF (Y_OFF), .MAX_SCALE (MAX_SCALE), .ZOOM_W (ZOOM_W),
        .ADDR_W (ADDR_W), .COLOR_W (COLOR_W), .RD_LAT (RD_LAT)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .zoom        (zoom),
        .border_rgb  (border_rgb),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .hsync       (hsync),
        .vsync       (vsync),
        .de          (de),
        .frame_start (frame_start),
        .red         (red),
        .gre         (gre),
        .blu         (blu)
    );

    always #5 clock = ~clock;

    // Synchronous RAM with RD_LAT cycles of read latency.
    logic [RGB_W-1:0] mem [1 << ADDR_W];
    logic [RGB_W-1:0] pipe [RD_LAT];
    always @(posedge clock) begin
        pipe[0] <= mem[rd_addr];
        for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign rd_data = pipe[RD_LAT-1];

    typedef struct packed {
        logic             hs;
        logic             vs;
        logic             de;
        logic             fs;
        logic [RGB_W-1:0] rgb;
    } out_t;

    typedef struct packed {
        logic              en;
        logic [ADDR_W-1:0] addr;
    } rd_t;

    out_t out_q[$];
    rd_t  rd_q[$];

    int   checks = 0;
    int   errors = 0;
    bit   run = 1'b0;
    int   n_prod = 0;
    int   m_mon = 0;
    int   cur_scale = 1;
    int   next_scale = 1;
    int   fidx = 0;
    int   zsel = 1;
    logic [RGB_W-1:0] cur_border = '0;
    int   zlist [10] = '{1, 2, 3, 0, 6, 4, 7, 1, 5, 2};

    // Reference model: one expected output tuple and RAM request per counter state.
    always @(negedge clock) begin : producer
        int pos, h, v, dx, dy, addr;
        bit act, win;
        out_t e;
        rd_t  r;
        if (!run) begin
            n_prod    = 0;
            cur_scale = 1;
            out_q.delete();
            rd_q.delete();
        end else begin
            pos = n_prod % FRAME;
            if (pos == 0) begin
                if (n_prod != 0) cur_scale = next_scale;
                cur_border = RGB_W'($urandom_range(0, 4095));
                border_rgb = cur_border;
                zsel       = zlist[fidx % 10];
                zoom       = ZOOM_W'(zsel);
                fidx++;
            end else if (pos < FRAME / 2) begin
                if ($urandom_range(0, 199) == 0) zoom = ZOOM_W'($urandom_range(0, 7));
            end else if (pos == FRAME / 2) begin
                zoom = ZOOM_W'(zsel);
            end
            if (pos == FRAME - 1) begin
                if (zoom == 0)                next_scale = 1;
                else if (int'(zoom) > MAX_SCALE) next_scale = MAX_SCALE;
                else                          next_scale = int'(zoom);
            end
            h   = pos % H_TOT;
            v   = pos / H_TOT;
            act = (h >= HA0) && (h < HA0 + H_ACTIVE) && (v >= VA0) && (v < VA0 + V_ACTIVE);
            dx  = h - HA0 - X_OFF;
            dy  = v - VA0 - Y_OFF;
            win = act && dx >= 0 && dx < IMG_W * cur_scale && dy >= 0 && dy < IMG_H * cur_scale;
            addr = win ? (dy / cur_scale) * IMG_W + dx / cur_scale : 0;
            e.hs  = (h < H_SYNC) ? SYNC_POL : ~SYNC_POL;
            e.vs  = (v < V_SYNC) ? SYNC_POL : ~SYNC_POL;
            e.de  = act;
            e.fs  = (h == HA0) && (v == VA0);
            e.rgb = win ? mem[addr] : (act ? cur_border : '0);
            r.en   = win;
            r.addr = ADDR_W'(addr);
            out_q.push_back(e);
            rd_q.push_back(r);
            n_prod++;
        end
    end

    always @(posedge clock or negedge reset_n) begin : monitor
        out_t e, got;
        rd_t  re, rg;
        if (!reset_n) begin
            m_mon = 0;
            #1;
            checks++;
            if (hsync !== ~SYNC_POL || vsync !== ~SYNC_POL || de !== 1'b0 ||
                frame_start !== 1'b0 || rd_en !== 1'b0 || rd_addr !== '0 ||
                {red, gre, blu} !== '0) begin
                errors++;
                $display("FAIL reset got hs=%b vs=%b de=%b fs=%b en=%b addr=%h rgb=%h",
                         hsync, vsync, de, frame_start, rd_en, rd_addr, {red, gre, blu});
            end
        end else if (run) begin
            m_mon++;
            #2;
            got = '{hs: hsync, vs: vsync, de: de, fs: frame_start, rgb: {red, gre, blu}};
            if (m_mon < L) begin
                e = '{hs: ~SYNC_POL, vs: ~SYNC_POL, de: 1'b0, fs: 1'b0, rgb: '0};
            end else if (out_q.size() == 0) begin
                e = '0;
                e.hs = 1'bx;
            end else begin
                e = out_q.pop_front();
            end
            checks++;
            if (got !== e) begin
                errors++;
                $display("FAIL pixel cyc=%0d got hs=%b vs=%b de=%b fs=%b rgb=%h want hs=%b vs=%b de=%b fs=%b rgb=%h",
                         m_mon, got.hs, got.vs, got.de, got.fs, got.rgb,
                         e.hs, e.vs, e.de, e.fs, e.rgb);
            end
            if (rd_q.size() == 0) begin
                re = '0;
                re.en = 1'bx;
            end else begin
                re = rd_q.pop_front();
            end
            rg.en   = rd_en;
            rg.addr = rd_en ? rd_addr : '0;
            checks++;
            if (rg !== re) begin
                errors++;
                $display("FAIL fetch cyc=%0d got en=%b addr=%0d want en=%b addr=%0d",
                         m_mon, rg.en, rg.addr, re.en, re.addr);
            end
        end
    end

    initial begin
        for (int i = 0; i < (1 << ADDR_W); i++) mem[i] = RGB_W'($urandom_range(0, 4095));
        #3 reset_n = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        run     = 1'b1;
        // Reset in the middle of a windowed line of a zoomed frame.
        repeat (10 * FRAME + 20 * H_TOT + 30) @(negedge clock);
        #1;
        reset_n = 1'b0;
        run     = 1'b0;
        repeat (3) @(posedge clock);
        #2;
        reset_n = 1'b1;
        run     = 1'b1;
        repeat (4 * FRAME + 50) @(posedge clock);
        #3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
